board_input_reader: RTL and testbench
=====================================

# board_input_reader

Input-side bring-up block for the Basys3: samples the 16 slide switches and 5 push-buttons, synchronises and debounces them, and presents clean levels plus single-cycle press/release/change events to the rest of the design. It is the receive-direction counterpart of the LED driver path and sits directly behind the top-level board pins.

## Interface
- TICK_CYCLES, 100000: clk cycles per debounce sample tick (1 ms at 100 MHz); minimum 2.
- STABLE_TICKS, 10: consecutive ticks an input must hold a new value before it is accepted; 1..15.
- REPEAT_DELAY_TICKS, 500: ticks a button is held before the first auto-repeat; used only with BTN_AUTOREPEAT_EN.
- REPEAT_RATE_TICKS, 100: ticks between subsequent auto-repeats; used only with BTN_AUTOREPEAT_EN.
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  reset, synchronous, active-low.
- sw_in  input  16  raw switch pins, asynchronous.
- btn_in  input  5  raw button pins (C,U,L,R,D), asynchronous, active-high.
- sw_state  output  16  debounced switch levels.
- sw_changed  output  1  one-cycle pulse when any sw_state bit toggles.
- btn_state  output  5  debounced button levels.
- btn_press  output  5  one-cycle pulse per button on debounced 0->1, and on auto-repeat.
- btn_release  output  5  one-cycle pulse per button on debounced 1->0.

## Operation
- Every raw input passes through a 2-flop synchroniser; only the second flop (sync) is used.
- Shared prescaler counts 0..TICK_CYCLES-1; tick is high for one cycle when it equals TICK_CYCLES-1, then wraps to 0.
- Per input: 4-bit stable counter cnt, debounced level state.
  - On tick with sync != state: if cnt == STABLE_TICKS-1, state <= sync and cnt <= 0; else cnt <= cnt+1.
  - On tick with sync == state: cnt <= 0 (bounce discards progress).
  - No tick: cnt and state hold. Activity between ticks is ignored.
- Events (registered, same edge as state update): btn_press[i] on state 0->1, btn_release[i] on 1->0, sw_changed if any switch state flips this edge. Multiple simultaneous flips give one sw_changed pulse and independent per-button pulses.
- Reset: all outputs, state, cnt, prescaler and synchroniser flops = 0. Inputs already high at reset-release therefore produce a normal debounced 0->1 (with pulses) after the filter delay.
- Reset asserted mid-count: counters and pending state changes are discarded; no pulse emitted in the reset cycle.

## Timing
- Latency from stable raw change to state/pulse: 2 sync cycles + time to the STABLE_TICKS-th tick at which sync differs; bounded by 2 + STABLE_TICKS*TICK_CYCLES cycles.
- Pulses are exactly one clk wide; outputs are registered, no combinational path from pins.
- Prescaler runs freely; not restarted by input activity.

## Configuration
- BTN_AUTOREPEAT_EN defined: per button a repeat counter, cleared when state is 0. While state is 1, counts ticks; at REPEAT_DELAY_TICKS after the press tick, btn_press pulses again, then every REPEAT_RATE_TICKS ticks until release. Release clears the counter; no repeat pulse on the release edge.
- Not defined: repeat logic absent; btn_press pulses once per debounced press only.

## Structure
- Package board_io_pkg: NUM_SW = 16, NUM_BTN = 5, button index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4.
- Sub-module input_debounce: one bit's synchroniser, cnt, state and rise/fall pulses; takes tick as input; instantiated 21 times. Prescaler, sw_changed OR-reduction and auto-repeat stay in the top.

## Test plan
Bench uses TICK_CYCLES=4, STABLE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2.
- Reset, all inputs 0, run 100 cycles -> all outputs 0, no pulses.
- sw_in[3] 0->1 held -> sw_state = 16'h0008 within 2+12 cycles, exactly one sw_changed pulse.
- btn_in[BTN_C] toggled every 3 cycles for 40 cycles, then held 1 -> no state change during bouncing; one btn_press after hold settles; release held -> one btn_release.
- sw_in = 16'hFFFF at reset release -> sw_state = 16'hFFFF after filter delay, single sw_changed pulse.
- Hold btn_in[BTN_U] 1 for 40 ticks with BTN_AUTOREPEAT_EN -> press pulses at debounce tick, +5 ticks, then every 2 ticks; without macro -> exactly one press.
- rst_n low for 1 cycle when cnt == 2 on a rising switch -> no state change or pulse; accepted only after a fresh 3 stable ticks.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants for the Basys3 board input path: switch/button counts
// and the button index map (C, U, L, R, D).
package board_io_pkg;

    localparam int NUM_SW  = 16;
    localparam int NUM_BTN = 5;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

endpackage

// File: rtl/input_debounce.sv
// Single-bit input conditioner: 2-flop synchroniser, tick-sampled stable
// counter, debounced level and registered rise/fall pulses.
// state_next exposes the level that will be taken at the coming edge so the
// parent can suppress work on the edge where the level is about to drop.
module input_debounce #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    input  logic tick,
    output logic state,
    output logic state_next,
    output logic rise,
    output logic fall
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_TICKS - 1);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic [3:0] cnt_q, cnt_d;
    logic       state_q, state_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    // Synchronise, then advance the stable counter only on sample ticks.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (tick) begin
            if (sync2_q != state_q) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = sync2_q;
                    cnt_d   = '0;
                    rise_d  = sync2_q;
                    fall_d  = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                // A sample matching the current level discards progress.
                cnt_d = '0;
            end
        end
    end

    // Register synchroniser, counter, level and edge pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign state      = state_q;
    assign state_next = state_d;
    assign rise       = rise_q;
    assign fall       = fall_q;

endmodule

// File: rtl/board_input_reader.sv
// Basys3 input reader: debounces 16 switches and 5 buttons against a shared
// sample-tick prescaler and presents clean levels plus one-cycle events.
// Optional feature: define BTN_AUTOREPEAT_EN to make held buttons re-emit
// btn_press after REPEAT_DELAY_TICKS, then every REPEAT_RATE_TICKS.
module board_input_reader
    import board_io_pkg::*;
#(
    parameter int TICK_CYCLES        = 100000,
    parameter int STABLE_TICKS       = 10,
    parameter int REPEAT_DELAY_TICKS = 500,
    parameter int REPEAT_RATE_TICKS  = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SW-1:0]  sw_in,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_SW-1:0]  sw_state,
    output logic               sw_changed,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    localparam int             PW        = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_CYCLES - 1);

    if (TICK_CYCLES < 2 || STABLE_TICKS < 1 || STABLE_TICKS > 15 ||
        REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_bad_params
        $error("board_input_reader: parameter out of range");
    end

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (presc_q == TICK_LAST);

    // Free-running prescaler; wraps after the tick cycle.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Register the prescaler.
    always_ff @(posedge clk) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    logic [NUM_SW-1:0]  sw_next_unused;
    logic [NUM_SW-1:0]  sw_rise, sw_fall;
    logic [NUM_BTN-1:0] btn_next;
    logic [NUM_BTN-1:0] btn_rise;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        input_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_in     (sw_in[i]),
            .tick       (tick),
            .state      (sw_state[i]),
            .state_next (sw_next_unused[i]),
            .rise       (sw_rise[i]),
            .fall       (sw_fall[i])
        );
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        input_debounce #(.STABLE_TICKS(STABLE_TICKS)) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw_in     (btn_in[i]),
            .tick       (tick),
            .state      (btn_state[i]),
            .state_next (btn_next[i]),
            .rise       (btn_rise[i]),
            .fall       (btn_release[i])
        );
    end

    // Any switch edge pulse on this cycle yields a single change event.
    assign sw_changed = |(sw_rise | sw_fall);

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [15:0] DELAY16 = 16'(REPEAT_DELAY_TICKS);
    localparam logic [15:0] RATE16  = 16'(REPEAT_RATE_TICKS);

    logic [NUM_BTN-1:0][15:0] rpt_cnt_q, rpt_cnt_d;
    logic [NUM_BTN-1:0]       rpt_first_q, rpt_first_d;
    logic [NUM_BTN-1:0]       rpt_q, rpt_d;

    // Count held ticks per button; fire after the delay, then at the rate.
    always_comb begin
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        rpt_d       = '0;
        for (int b = 0; b < NUM_BTN; b++) begin
            if (!btn_state[b] || !btn_next[b]) begin
                // Released, or releasing on this edge: no repeat, restart.
                rpt_cnt_d[b]   = '0;
                rpt_first_d[b] = 1'b0;
            end else if (tick) begin
                if (rpt_cnt_q[b] + 16'd1 == (rpt_first_q[b] ? RATE16 : DELAY16)) begin
                    rpt_d[b]       = 1'b1;
                    rpt_cnt_d[b]   = '0;
                    rpt_first_d[b] = 1'b1;
                end else begin
                    rpt_cnt_d[b] = rpt_cnt_q[b] + 16'd1;
                end
            end
        end
    end

    // Register repeat counters and pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= '0;
            rpt_q       <= '0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
            rpt_q       <= rpt_d;
        end
    end

    assign btn_press = btn_rise | rpt_q;
`else
    logic [NUM_BTN-1:0] btn_next_unused;
    assign btn_next_unused = btn_next;
    assign btn_press       = btn_rise;
`endif

endmodule

// File: tb/tb_board_input_reader.sv
// Self-checking bench for board_input_reader with a behavioural model of
// sampling, debouncing and auto-repeat; directed scenarios plus random holds.
module tb_board_input_reader;
    import board_io_pkg::*;

    localparam int TICK   = 4;
    localparam int STABLE = 3;
    localparam int DELAY  = 5;
    localparam int RATE   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_in;
    logic [4:0]  btn_in;
    logic [15:0] sw_state;
    logic        sw_changed;
    logic [4:0]  btn_state;
    logic [4:0]  btn_press;
    logic [4:0]  btn_release;

    always #5 clk = ~clk;

    board_input_reader #(
        .TICK_CYCLES        (TICK),
        .STABLE_TICKS       (STABLE),
        .REPEAT_DELAY_TICKS (DELAY),
        .REPEAT_RATE_TICKS  (RATE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_in       (sw_in),
        .btn_in      (btn_in),
        .sw_state    (sw_state),
        .sw_changed  (sw_changed),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [20:0] m_state;
    int        m_run [21];
    bit [20:0] raw_d1, raw_d2;
    int        m_n;
    int        m_held [5];
    bit        e_chg;
    bit [4:0]  e_press, e_rel;

    task automatic model_step();
        bit [20:0] raw;
        bit [20:0] smp;
        bit [20:0] old;
        bit        tk;
        raw     = {btn_in, sw_in};
        e_chg   = 1'b0;
        e_press = '0;
        e_rel   = '0;
        if (!rst_n) begin
            m_state = '0;
            raw_d1  = '0;
            raw_d2  = '0;
            m_n     = 0;
            for (int i = 0; i < 21; i++) m_run[i] = 0;
            for (int b = 0; b < 5; b++) m_held[b] = 0;
            return;
        end
        tk  = ((m_n % TICK) == TICK - 1);
        m_n++;
        smp    = raw_d2;
        raw_d2 = raw_d1;
        raw_d1 = raw;
        old    = m_state;
        if (tk) begin
            for (int i = 0; i < 21; i++) begin
                if (smp[i] != m_state[i]) begin
                    m_run[i]++;
                    if (m_run[i] == STABLE) begin
                        m_state[i] = smp[i];
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
        e_chg = |(old[15:0] ^ m_state[15:0]);
        for (int b = 0; b < 5; b++) begin
            e_press[b] = !old[16+b] && m_state[16+b];
            e_rel[b]   = old[16+b] && !m_state[16+b];
`ifdef BTN_AUTOREPEAT_EN
            if (!m_state[16+b]) m_held[b] = 0;
            else if (tk && old[16+b]) begin
                m_held[b]++;
                if (m_held[b] == DELAY ||
                    (m_held[b] > DELAY && ((m_held[b] - DELAY) % RATE) == 0))
                    e_press[b] = 1'b1;
            end
`endif
        end
    endtask

    // ---------------- cycle driver and tallies ----------------
    int n_chg;
    int n_press [5];
    int n_rel   [5];
    int cyc_no;
    int press_u_q [$];

    task automatic clear_tally();
        n_chg  = 0;
        cyc_no = 0;
        for (int b = 0; b < 5; b++) begin
            n_press[b] = 0;
            n_rel[b]   = 0;
        end
        press_u_q.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_eq("sw_state",    32'(sw_state),    32'(m_state[15:0]));
        check_eq("sw_changed",  32'(sw_changed),  32'(e_chg));
        check_eq("btn_state",   32'(btn_state),   32'(m_state[20:16]));
        check_eq("btn_press",   32'(btn_press),   32'(e_press));
        check_eq("btn_release", 32'(btn_release), 32'(e_rel));
        if (sw_changed) n_chg++;
        for (int b = 0; b < 5; b++) begin
            if (btn_press[b]) begin
                n_press[b]++;
                if (b == BTN_U) press_u_q.push_back(cyc_no);
            end
            if (btn_release[b]) n_rel[b]++;
        end
        cyc_no++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    initial begin
        int tot;
        int exp_cnt;
        rst_n  = 1'b0;
        sw_in  = '0;
        btn_in = '0;
        clear_tally();
        @(negedge clk);
        run(3);
        rst_n = 1'b1;

        // Idle after reset: nothing happens.
        clear_tally();
        run(100);
        tot = 0;
        for (int b = 0; b < 5; b++) tot += n_press[b] + n_rel[b];
        check_eq("idle_chg_cnt", n_chg, 0);
        check_eq("idle_btn_evt", tot, 0);
        check_eq("idle_sw_state", 32'(sw_state), 0);

        // Single switch rise.
        clear_tally();
        sw_in[3] = 1'b1;
        run(14);
        check_eq("sw3_state", 32'(sw_state), 32'h0008);
        run(10);
        check_eq("sw3_chg_cnt", n_chg, 1);

        // Bouncing centre button, then steady press and release.
        clear_tally();
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) btn_in[BTN_C] = ~btn_in[BTN_C];
            cyc();
        end
        check_eq("bounce_press_cnt", n_press[BTN_C], 0);
        check_eq("bounce_btn_state", 32'(btn_state[BTN_C]), 0);
        btn_in[BTN_C] = 1'b1;
        run(16);
        check_eq("hold_press_cnt", n_press[BTN_C], 1);
        check_eq("hold_btn_state", 32'(btn_state[BTN_C]), 1);
        btn_in[BTN_C] = 1'b0;
        run(16);
        check_eq("rel_cnt", n_rel[BTN_C], 1);
        check_eq("rel_btn_state", 32'(btn_state[BTN_C]), 0);

        // All switches high across reset release.
        rst_n = 1'b0;
        sw_in = 16'hFFFF;
        run(2);
        rst_n = 1'b1;
        clear_tally();
        run(14);
        check_eq("all_sw_state", 32'(sw_state), 32'hFFFF);
        run(6);
        check_eq("all_sw_chg_cnt", n_chg, 1);
        sw_in = '0;
        run(20);

        // Long hold of the up button.
        clear_tally();
        btn_in[BTN_U] = 1'b1;
        run(160);
`ifdef BTN_AUTOREPEAT_EN
        exp_cnt = 0;
        if (press_u_q.size() > 0) begin
            exp_cnt = 1;
            if (159 - press_u_q[0] >= DELAY * TICK)
                exp_cnt += 1 + (159 - press_u_q[0] - DELAY * TICK) / (RATE * TICK);
        end
        check_eq("rpt_press_cnt", n_press[BTN_U], exp_cnt);
        if (press_u_q.size() >= 2)
            check_eq("rpt_first_gap", press_u_q[1] - press_u_q[0], DELAY * TICK);
        for (int i = 2; i < press_u_q.size(); i++)
            check_eq("rpt_gap", press_u_q[i] - press_u_q[i-1], RATE * TICK);
`else
        exp_cnt = 1;
        check_eq("hold_u_press_cnt", n_press[BTN_U], exp_cnt);
`endif
        btn_in[BTN_U] = 1'b0;
        run(20);

        // Reset pulse while a switch rise is two ticks into its count.
        rst_n = 1'b0;
        run(2);
        rst_n    = 1'b1;
        sw_in[5] = 1'b1;
        run(9);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        clear_tally();
        run(10);
        check_eq("rstmid_sw_state", 32'(sw_state), 0);
        check_eq("rstmid_chg_cnt", n_chg, 0);
        run(4);
        check_eq("rstmid_sw_late", 32'(sw_state), 32'h0020);
        check_eq("rstmid_chg_late", n_chg, 1);

        // Random bounce-then-hold segments, with occasional resets.
        for (int s = 0; s < 60; s++) begin
            logic [15:0] tsw;
            logic [4:0]  tbtn;
            tsw  = 16'($urandom);
            tbtn = 5'($urandom);
            for (int k = 0; k < int'($urandom_range(0, 10)); k++) begin
                sw_in  = 16'($urandom);
                btn_in = 5'($urandom);
                cyc();
            end
            sw_in  = tsw;
            btn_in = tbtn;
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            run($urandom_range(5, 60));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
